imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Encoder counterpart of the core's immediate sign-extender: packs a 32-bit immediate plus register and function fields into a 32-bit RV32I instruction word.
- Selects I, S, B or J layout using the same ImmSrc encoding the decode path uses.
- Used by the self-test program loader to stream instructions into instruction memory: a one-deep registered output stage with a valid/ready handshake, a byte address counter and a sticky immediate-range error.

Parameters:
- ADDR_WIDTH, 8, width of the emitted byte address.
- BASE_ADDR, 0, address of the first emitted word; must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- restart  in  1  synchronous restart of address, error and pending output
- in_valid  in  1  request fields are valid
- in_ready  out  1  block accepts a request this cycle
- ImmSrc  in  3  000 I, 001 S, 010 B, 011 J, others illegal
- imm  in  32  signed byte-offset / immediate value
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  instr[14:12]
- out_valid  out  1  instr/addr valid
- out_ready  in  1  consumer accepts the word
- instr  out  32  encoded instruction
- addr  out  ADDR_WIDTH  byte address of instr
- range_err  out  1  sticky: some immediate did not fit its format
- err_addr  out  ADDR_WIDTH  address of the first offending word

Behaviour:
- Reset, asynchronous: out_valid=0, instr=0, addr=BASE_ADDR, range_err=0, err_addr=0.
- in_ready = !out_valid || out_ready.
  - Input handshake = in_valid && in_ready.
  - The encoded word is registered, so out_valid rises the cycle after acceptance (latency 1).
  - Full throughput: a drain and a new accept may happen in the same cycle.
- While out_valid && !out_ready, instr and addr are held stable.
- Encodings:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Illegal ImmSrc: instr = 32'h00000013 (NOP).
- Range check, evaluated at acceptance:
  - I/S: imm[31:11] must be all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - Illegal ImmSrc counts as a violation.
  - On violation the word is still emitted with truncated fields and range_err is set.
  - err_addr captures the address of the first violating word only, while range_err=0.
- Address counter:
  - addr is the address the current output word will occupy.
  - It advances by 4 on each output handshake (out_valid && out_ready).
  - It wraps modulo 2^ADDR_WIDTH with no flag.
- restart has priority over all handshakes:
  - That cycle: in_ready=0, no input accepted, any pending output is discarded.
  - Next cycle: out_valid=0, addr=BASE_ADDR, range_err=0, err_addr=0.
- Reset asserted mid-stall discards the pending word immediately.
- No combinational path from out_ready to instr or addr; in_ready depends combinationally on out_ready and restart.

Decomposition:
- Shared package:
  - ImmSrc enum (IMM_I=3'b000, IMM_S, IMM_B, IMM_J), already used by the decode path.
  - NOP constant 32'h00000013.
  - Opcode constants OP_IMM, STORE, BRANCH, JAL.
- One natural sub-module: imm_pack_comb, a purely combinational field packer plus range checker (ImmSrc, imm, fields -> word, fits).
- The top holds the output register, handshake, address counter and error capture.

Test Plan:
- Encoding, one accept each with out_ready=1; words emerge on consecutive cycles at addr 0,4,8,12 and range_err stays 0:
  - addi: I, imm=5, rd=1, rs1=0, funct3=000, opcode=0010011 -> instr=0x00500093.
  - sw: S, imm=8, rs2=2, rs1=3, funct3=010, opcode=0100011 -> 0x0021A423.
  - bne: B, imm=-4, rs1=1, rs2=0, funct3=001, opcode=1100011 -> 0xFE009EE3.
  - jal: J, imm=8, rd=1, opcode=1101111 -> 0x008000EF.
- Range error: I, imm=2048, rd=1, opcode=0010011 at addr 0x10 -> instr=0x80000093, range_err=1, err_addr=0x10; a later B with imm=3 keeps err_addr=0x10.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/addr stable; on out_ready=1 the next word is accepted in the same cycle and appears the following cycle with addr advanced by 4.
- Wrap: ADDR_WIDTH=4, BASE_ADDR=12, two words -> addr 12 then 0.
- Restart and reset: restart during a stalled output -> word dropped, out_valid=0, addr=BASE_ADDR, range_err=0 next cycle; async rst mid-stream -> all outputs at reset values without waiting for a clk edge.
- Illegal ImmSrc=3'b101 -> instr=0x00000013, range_err=1.

Source files
------------

// File: rtl/imm_packer_pkg.sv
// Shared definitions for the immediate packer and the decode path.
package imm_packer_pkg;

    // Immediate layout selector, shared with the decode-side sign-extender.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011
    } imm_src_e;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    // True when every bit of the given slice matches its neighbour (pure sign extension).
    function automatic logic all_same(input logic [31:0] v, input int unsigned lsb);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = lsb; i < 31; i++) begin
            if (v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack_comb.sv
// Combinational RV32I field packer with immediate range check.
module imm_pack_comb
    import imm_packer_pkg::*;
(
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic [31:0] word,
    output logic        fits
);

    // Select layout and judge whether the immediate survives truncation.
    always_comb begin
        word = NOP;
        fits = 1'b0;
        case (ImmSrc)
            IMM_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                fits = all_same(imm, 11);
            end
            IMM_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                fits = all_same(imm, 11);
            end
            IMM_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                fits = all_same(imm, 12) && !imm[0];
            end
            IMM_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                fits = all_same(imm, 20) && !imm[0];
            end
            default: begin
                // Unknown layout: emit a harmless NOP but flag it.
                word = NOP;
                fits = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_packer.sv
// Registered instruction packer with valid/ready output, address counter and sticky range error.
module imm_packer
    import imm_packer_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ImmSrc,
    input  logic [31:0]           imm,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  range_err,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    logic [31:0]           packed_word;
    logic                  fits;
    logic                  valid_q;
    logic [31:0]           instr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                  accept;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] word_addr;

    imm_pack_comb u_pack (
        .ImmSrc (ImmSrc),
        .imm    (imm),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .word   (packed_word),
        .fits   (fits)
    );

    // Handshake decode; restart blocks both sides for the cycle.
    always_comb begin
        in_ready  = !restart && (!valid_q || out_ready);
        accept    = in_valid && in_ready;
        drain     = !restart && valid_q && out_ready;
        addr_next = addr_q + ADDR_WIDTH'(4);
        // A word accepted alongside a drain lands at the following slot.
        word_addr = drain ? addr_next : addr_q;
    end

    // Output register, address counter and first-error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (restart) begin
            valid_q    <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (drain) begin
                addr_q <= addr_next;
            end
            if (accept) begin
                valid_q <= 1'b1;
                instr_q <= packed_word;
                if (!fits && !err_q) begin
                    err_q      <= 1'b1;
                    err_addr_q <= word_addr;
                end
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign instr     = instr_q;
    assign addr      = addr_q;
    assign range_err = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed table, corner sequences, randomized model check.
module tb_imm_packer;

    logic        clk;
    logic        rst;
    logic        restart;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] instr;
    logic [7:0]  addr;
    logic        range_err;
    logic [7:0]  err_addr;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_instr;
    logic [3:0]  w_addr;
    logic        w_range_err;
    logic [3:0]  w_err_addr;

    int total;
    int bad;

    imm_packer #(
        .ADDR_WIDTH (8),
        .BASE_ADDR  (8'd0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .addr      (addr),
        .range_err (range_err),
        .err_addr  (err_addr)
    );

    imm_packer #(
        .ADDR_WIDTH (4),
        .BASE_ADDR  (4'd12)
    ) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .ImmSrc    (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .instr     (w_instr),
        .addr      (w_addr),
        .range_err (w_range_err),
        .err_addr  (w_err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] exp_instr;
        logic [7:0]  exp_addr;
        logic        exp_err;
        logic [7:0]  exp_err_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        imm_src = v.src;
        imm     = v.imm;
        opcode  = v.op;
        rd      = v.rd;
        rs1     = v.rs1;
        rs2     = v.rs2;
        funct3  = v.f3;
    endtask

    // Reference encoder built from bit arithmetic on the field definitions.
    function automatic logic [31:0] model_word(input logic [2:0] s, input logic [31:0] u,
                                               input logic [6:0] op, input logic [4:0] d,
                                               input logic [4:0] a, input logic [4:0] b,
                                               input logic [2:0] f);
        logic [31:0] o, rdw, r1, r2, fw;
        o = 32'(op); rdw = 32'(d); r1 = 32'(a); r2 = 32'(b); fw = 32'(f);
        case (s)
            3'd0: return ((u & 32'hFFF) << 20) | (r1 << 15) | (fw << 12) | (rdw << 7) | o;
            3'd1: return (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (fw << 12)
                         | ((u & 32'h1F) << 7) | o;
            3'd2: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20)
                         | (r1 << 15) | (fw << 12) | (((u >> 1) & 32'hF) << 8)
                         | (((u >> 11) & 1) << 7) | o;
            3'd3: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                         | (rdw << 7) | o;
            default: return 32'h0000_0013;
        endcase
    endfunction

    // Reference range check as signed interval tests.
    function automatic logic model_fits(input logic [2:0] s, input logic [31:0] u);
        int v;
        v = int'(u);
        case (s)
            3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
            3'd2: return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
            3'd3: return (v >= -(1 << 20)) && (v < (1 << 20)) && (v % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic        mv, nv, merr, nerr, exp_ir, ok;
        logic [31:0] minstr, ninstr;
        logic [7:0]  maddr, naddr, merr_addr, nerr_addr;

        total = 0;
        bad   = 0;

        //             src    imm            op       rd    rs1   rs2   f3    instr          addr   err  eaddr
        vecs[0] = '{3'd0, 32'd5,         7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00500093, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{3'd1, 32'd8,         7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'h0021A423, 8'h04, 1'b0, 8'h00};
        vecs[2] = '{3'd2, 32'hFFFFFFFC,  7'h63, 5'd0, 5'd1, 5'd0, 3'd1, 32'hFE009EE3, 8'h08, 1'b0, 8'h00};
        vecs[3] = '{3'd3, 32'd8,         7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h008000EF, 8'h0C, 1'b0, 8'h00};
        vecs[4] = '{3'd0, 32'd2048,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h80000093, 8'h10, 1'b1, 8'h10};
        vecs[5] = '{3'd2, 32'd3,         7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000163, 8'h14, 1'b1, 8'h10};
        vecs[6] = '{3'd5, 32'd0,         7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000013, 8'h18, 1'b1, 8'h10};

        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        apply(vecs[0]);
        repeat (2) tick;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_wrap_addr", 32'(w_addr), 32'd12);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table, back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1;
            tick;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_err", i), 32'(range_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_err_addr", i), 32'(err_addr), 32'(vecs[i].exp_err_addr));
        end
        in_valid = 1'b0;
        tick;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_addr", 32'(addr), 32'h1C);

        // Restart clears address and error
        restart = 1'b1; in_valid = 1'b1;
        #1;
        chk("restart_in_ready", 32'(in_ready), 32'd0);
        tick;
        restart = 1'b0; in_valid = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd0);
        chk("restart_addr", 32'(addr), 32'd0);
        chk("restart_err", 32'(range_err), 32'd0);
        chk("restart_err_addr", 32'(err_addr), 32'd0);
        chk("restart_wrap_addr", 32'(w_addr), 32'd12);

        // Backpressure: stall three cycles, then drain+accept in one cycle
        out_ready = 1'b0; in_valid = 1'b1;
        apply(vecs[0]);
        tick;
        chk("bp_first_instr", instr, 32'h00500093);
        apply(vecs[6]);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            tick;
            chk($sformatf("bp%0d_instr", i), instr, 32'h00500093);
            chk($sformatf("bp%0d_addr", i), 32'(addr), 32'd0);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("bp_next_instr", instr, 32'h00000013);
        chk("bp_next_addr", 32'(addr), 32'd4);
        chk("bp_next_err", 32'(range_err), 32'd1);
        chk("bp_next_err_addr", 32'(err_addr), 32'd4);

        // Restart during a stalled output drops the word
        in_valid = 1'b0; out_ready = 1'b0;
        tick;
        restart = 1'b1;
        #1;
        chk("rs_stall_in_ready", 32'(in_ready), 32'd0);
        tick;
        restart = 1'b0;
        chk("rs_stall_valid", 32'(out_valid), 32'd0);
        chk("rs_stall_addr", 32'(addr), 32'd0);
        chk("rs_stall_err", 32'(range_err), 32'd0);

        // Wrap on the 4-bit instance: 12 then 0
        out_ready = 1'b1; in_valid = 1'b1;
        apply(vecs[0]);
        tick;
        chk("wrap_first_addr", 32'(w_addr), 32'd12);
        chk("wrap_first_valid", 32'(w_out_valid), 32'd1);
        apply(vecs[1]);
        tick;
        chk("wrap_second_addr", 32'(w_addr), 32'd0);
        chk("wrap_second_instr", w_instr, 32'h0021A423);
        in_valid = 1'b0;
        tick;

        // Async reset mid-stall, checked before any clock edge
        in_valid = 1'b1; out_ready = 1'b0;
        apply(vecs[4]);
        tick;
        in_valid = 1'b0;
        chk("ar_pending_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_instr", instr, 32'd0);
        chk("ar_addr", 32'(addr), 32'd0);
        chk("ar_err", 32'(range_err), 32'd0);
        chk("ar_wrap_addr", 32'(w_addr), 32'd12);
        tick;
        rst = 1'b0;

        // Randomized run against the reference model
        mv = 1'b0; minstr = '0; maddr = 8'd0; merr = 1'b0; merr_addr = 8'd0;
        for (int c = 0; c < 400; c++) begin
            restart   = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            imm_src   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                    : 3'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'(int'($urandom_range(0, 4200)) - 2100);
                2: imm = 32'(int'($urandom_range(0, 10000)) - 5000);
                default: imm = 32'(int'($urandom_range(0, 1 << 22)) - (1 << 21));
            endcase
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
            rs2 = 5'($urandom); funct3 = 3'($urandom);
            #1;
            exp_ir = !restart && (!mv || out_ready);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));

            nv = mv; ninstr = minstr; naddr = maddr; nerr = merr; nerr_addr = merr_addr;
            if (restart) begin
                nv = 1'b0; naddr = 8'd0; nerr = 1'b0; nerr_addr = 8'd0;
            end else begin
                if (mv && out_ready) begin
                    naddr = maddr + 8'd4;
                    nv    = 1'b0;
                end
                if (in_valid && exp_ir) begin
                    nv     = 1'b1;
                    ninstr = model_word(imm_src, imm, opcode, rd, rs1, rs2, funct3);
                    ok     = model_fits(imm_src, imm);
                    if (!ok && !merr) begin
                        nerr      = 1'b1;
                        nerr_addr = naddr;
                    end
                end
            end
            tick;
            mv = nv; minstr = ninstr; maddr = naddr; merr = nerr; merr_addr = nerr_addr;
            chk("rnd_valid", 32'(out_valid), 32'(mv));
            if (mv) chk("rnd_instr", instr, minstr);
            chk("rnd_addr", 32'(addr), 32'(maddr));
            chk("rnd_err", 32'(range_err), 32'(merr));
            chk("rnd_err_addr", 32'(err_addr), 32'(merr_addr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
